// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 32-point FFT datapath.
package fft_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned FFT_N     = 32;
  localparam int unsigned FFT_LOG2N = $clog2(FFT_N);

  typedef enum logic {StIdle, StStream} ser_state_e;

  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned width);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < width; b++) r = (r << 1) | ((idx >> b) & 1);
    return r;
  endfunction

  // Slot i of a flat bus lives at [(i+1)*width-1 : i*width].
  function automatic int unsigned slot_lsb(input int unsigned slot, input int unsigned width);
    return slot * width;
  endfunction

endpackage

// File: rtl/fft_out_serializer_if.sv
// Parallel-frame in / serial-sample out bundle for fft_out_serializer.
// master = frame source and sample consumer; slave = the serializer.
interface fft_out_serializer_if
  import fft_pkg::*;
#(
  parameter int unsigned data_width = DATA_W,
  parameter int unsigned no_in_out  = FFT_N
) ();
  localparam int unsigned IDX_W = $clog2(no_in_out);

  logic                            in_valid;
  logic                            in_ready;
  logic [no_in_out*data_width-1:0] input_data_real;
  logic [no_in_out*data_width-1:0] input_data_imag;
  logic                            out_valid;
  logic                            out_ready;
  logic [data_width-1:0]           output_real;
  logic [data_width-1:0]           output_imag;
  logic [IDX_W-1:0]                out_index;
  logic                            out_last;

  modport master (
    output in_valid, input_data_real, input_data_imag, out_ready,
    input  in_ready, out_valid, output_real, output_imag, out_index, out_last
  );

  modport slave (
    input  in_valid, input_data_real, input_data_imag, out_ready,
    output in_ready, out_valid, output_real, output_imag, out_index, out_last
  );
endinterface

// File: rtl/fft_bitrev_index.sv
// Combinational bit reversal of a Width-bit index; shared with the stage mappers.
module fft_bitrev_index
  import fft_pkg::*;
#(
  parameter int unsigned Width = FFT_LOG2N
) (
  input  logic [Width-1:0] i_idx,
  output logic [Width-1:0] o_idx
);
  for (genvar b = 0; b < Width; b++) begin : g_rev
    assign o_idx[b] = i_idx[Width-1-b];
  end
endmodule

// File: rtl/fft_out_serializer.sv
// Streams a bit-reversed parallel FFT frame out serially in natural order.
// Define FFT_OUT_PINGPONG_EN to add a shadow buffer for gapless back-to-back frames.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int unsigned data_width = DATA_W,
  parameter int unsigned no_in_out  = FFT_N
) (
  input logic clk,
  input logic rst,
  fft_out_serializer_if.slave bus
);
  localparam int unsigned     IDX_W    = $clog2(no_in_out);
  localparam int unsigned     BUS_W    = no_in_out * data_width;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(no_in_out - 1);

  ser_state_e       r_state, w_state_d;
  logic [IDX_W-1:0] r_cnt, w_cnt_d, w_slot;
  logic [BUS_W-1:0] r_act_re, r_act_im;
  logic             w_in_fire, w_out_fire, w_last, w_load_act;

`ifdef FFT_OUT_PINGPONG_EN
  logic [BUS_W-1:0] r_shd_re, r_shd_im;
  logic             r_shadow_full, w_shadow_full_d, w_load_shadow, w_shift_shadow;
  assign bus.in_ready = !r_shadow_full;
`else
  assign bus.in_ready = (r_state == StIdle);
`endif

  assign w_in_fire  = bus.in_valid & bus.in_ready;
  assign w_out_fire = (r_state == StStream) & bus.out_ready;
  assign w_last     = (r_cnt == LAST_IDX);

  fft_bitrev_index #(
    .Width (IDX_W)
  ) u_bitrev (
    .i_idx (r_cnt),
    .o_idx (w_slot)
  );

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_load_act = 1'b0;
`ifdef FFT_OUT_PINGPONG_EN
    w_load_shadow   = 1'b0;
    w_shift_shadow  = 1'b0;
    w_shadow_full_d = r_shadow_full;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_in_fire) begin
          w_load_act = 1'b1;
          w_cnt_d    = '0;
          w_state_d  = StStream;
        end
      end
      StStream: begin
        if (w_out_fire) begin
          w_cnt_d = r_cnt + IDX_W'(1);
          if (w_last) begin
            w_cnt_d   = '0;
            w_state_d = StIdle;
`ifdef FFT_OUT_PINGPONG_EN
            if (r_shadow_full) begin
              w_shift_shadow  = 1'b1;
              w_shadow_full_d = 1'b0;
              w_state_d       = StStream;
            end else if (w_in_fire) begin
              // Frame arriving on the final handshake bypasses the shadow.
              w_load_act = 1'b1;
              w_state_d  = StStream;
            end
`endif
          end
        end
`ifdef FFT_OUT_PINGPONG_EN
        if (w_in_fire && !(w_out_fire && w_last)) begin
          w_load_shadow   = 1'b1;
          w_shadow_full_d = 1'b1;
        end
`endif
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_act_re <= '0;
      r_act_im <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_load_act) begin
        r_act_re <= bus.input_data_real;
        r_act_im <= bus.input_data_imag;
`ifdef FFT_OUT_PINGPONG_EN
      end else if (w_shift_shadow) begin
        r_act_re <= r_shd_re;
        r_act_im <= r_shd_im;
`endif
      end
    end
  end

`ifdef FFT_OUT_PINGPONG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shd_re      <= '0;
      r_shd_im      <= '0;
      r_shadow_full <= 1'b0;
    end else begin
      r_shadow_full <= w_shadow_full_d;
      if (w_load_shadow) begin
        r_shd_re <= bus.input_data_real;
        r_shd_im <= bus.input_data_imag;
      end
    end
  end
`endif

  always_comb begin
    bus.out_valid   = 1'b0;
    bus.out_index   = '0;
    bus.out_last    = 1'b0;
    bus.output_real = '0;
    bus.output_imag = '0;
    if (r_state == StStream) begin
      bus.out_valid   = 1'b1;
      bus.out_index   = r_cnt;
      bus.out_last    = w_last;
      bus.output_real = r_act_re[w_slot*data_width +: data_width];
      bus.output_imag = r_act_im[w_slot*data_width +: data_width];
    end
  end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Randomised bench for fft_out_serializer against a queue-based frame model.
module tb_fft_out_serializer;
  localparam int DW = 8;
  localparam int N  = 32;

  typedef struct {
    int         k;
    logic [7:0] re;
    logic [7:0] im;
    bit         last;
  } samp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_out_serializer_if #(.data_width(DW), .no_in_out(N)) bus ();

  fft_out_serializer #(.data_width(DW), .no_in_out(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  samp_t      exp_q[$];
  logic [7:0] log_re[$];
  logic [7:0] log_im[$];
  int         log_k[$];
  logic [7:0] fr_re[N];
  logic [7:0] fr_im[N];
  int         out_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int brev(input int idx);
    int r = 0;
    for (int b = 0; b < 5; b++) r = (r << 1) | ((idx >> b) & 1);
    return r;
  endfunction

  // Source can hand over a frame when no frame is queued (single) or when the
  // pending work fits in one buffer's worth beyond the active frame (pingpong).
  function automatic bit exp_in_ready();
`ifdef FFT_OUT_PINGPONG_EN
    return exp_q.size() <= N;
`else
    return exp_q.size() == 0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      bit cap;
      cap = bus.in_valid && exp_in_ready();
      if (exp_q.size() > 0 && bus.out_ready) begin
        void'(exp_q.pop_front());
        if (bus.out_valid) begin
          log_re.push_back(bus.output_real);
          log_im.push_back(bus.output_imag);
          log_k.push_back(int'(bus.out_index));
        end
      end
      if (cap) begin
        for (int k = 0; k < N; k++) begin
          samp_t s;
          s.k    = k;
          s.re   = bus.input_data_real[brev(k)*DW +: DW];
          s.im   = bus.input_data_imag[brev(k)*DW +: DW];
          s.last = (k == N - 1);
          exp_q.push_back(s);
        end
      end
    end
  end

  bit         prev_stall = 0;
  logic [7:0] prev_re;
  logic [4:0] prev_idx;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      check("out_valid", bus.out_valid, exp_q.size() > 0);
      check("in_ready", bus.in_ready, exp_in_ready());
      if (exp_q.size() > 0 && bus.out_valid) begin
        check("out_index", bus.out_index, exp_q[0].k);
        check("output_real", bus.output_real, exp_q[0].re);
        check("output_imag", bus.output_imag, exp_q[0].im);
        check("out_last", bus.out_last, exp_q[0].last);
      end
      if (prev_stall && bus.out_valid) begin
        check("stall_hold_real", bus.output_real, prev_re);
        check("stall_hold_index", bus.out_index, prev_idx);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_re    = bus.output_real;
      prev_idx   = bus.out_index;
    end
  end

  always @(posedge clk) begin
    #1;
    case (out_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ~bus.out_ready;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic ramp_frame();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 8'(i);
      fr_im[i] = ~8'(i);
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 8'($urandom);
      fr_im[i] = 8'($urandom);
    end
  endtask

  task automatic clear_log();
    log_re.delete();
    log_im.delete();
    log_k.delete();
  endtask

  task automatic send_frame();
    bit acc = 0;
    for (int i = 0; i < N; i++) begin
      bus.input_data_real[i*DW +: DW] = fr_re[i];
      bus.input_data_imag[i*DW +: DW] = fr_im[i];
    end
    bus.in_valid = 1'b1;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(posedge clk);
      acc = bus.in_ready;
    end
    #1 bus.in_valid = 1'b0;
    if (!acc) check("send_frame_timeout", 0, 1);
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (i >= budget) check("drain_timeout", 0, 1);
  endtask

  task automatic wait_index(input int k);
    int i = 0;
    @(negedge clk);
    while (!(bus.out_valid && int'(bus.out_index) == k) && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (i >= 200) check("wait_index_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.input_data_real = '0;
    bus.input_data_imag = '0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_index", bus.out_index, 0);
    check("rst_output_real", bus.output_real, 0);
    check("rst_output_imag", bus.output_imag, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Ramp frame, always ready.
    ramp_frame();
    clear_log();
    send_frame();
    wait_drain(200);
    check("ramp_count", log_re.size(), 32);
    check("ramp_re0", log_re[0], 0);
    check("ramp_re1", log_re[1], 16);
    check("ramp_re2", log_re[2], 8);
    check("ramp_re3", log_re[3], 24);
    check("ramp_re4", log_re[4], 4);
    check("ramp_re31", log_re[31], 31);
    check("ramp_im1", log_im[1], 8'hEF);
    check("ramp_k31", log_k[31], 31);
    check("idle_after_last", bus.out_valid, 0);

    // Alternating back-pressure.
    out_mode = 1;
    clear_log();
    send_frame();
    wait_drain(400);
    check("bp_count", log_re.size(), 32);
    check("bp_re5", log_re[5], 20);
    check("bp_k17", log_k[17], 17);
    out_mode = 0;

    // Second frame offered while the first streams.
    clear_log();
    rand_frame();
    send_frame();
    rand_frame();
    send_frame();
    wait_drain(400);
    check("b2b_count", log_re.size(), 64);
    check("b2b_second_re0", log_re[32], fr_re[0]);

    // Reset in the middle of a frame.
    ramp_frame();
    send_frame();
    wait_index(13);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_index", bus.out_index, 0);
    check("midrst_output_real", bus.output_real, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    rand_frame();
    send_frame();
    wait_drain(200);
    check("postrst_count", log_re.size(), 32);
    check("postrst_k0", log_k[0], 0);
    check("postrst_re0", log_re[0], fr_re[0]);

    // Next frame presented exactly during the last handshake.
    clear_log();
    rand_frame();
    send_frame();
    wait_index(31);
    rand_frame();
    send_frame();
    wait_drain(400);
    check("simul_count", log_re.size(), 64);
    check("simul_second_re1", log_re[33], fr_re[16]);

    // Random frames with random back-pressure and gaps.
    out_mode = 2;
    for (int f = 0; f < 8; f++) begin
      rand_frame();
      send_frame();
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
    end
    wait_drain(3000);
    out_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
